// File: rtl/fb_write_sched_if.sv
// Bus bundle for the framebuffer write scheduler: rasterizer stream, fill command
// and the registered pixel-write port toward the framebuffer.
interface fb_write_sched_if;
    logic        rast_valid;
    logic        rast_ready;
    logic [10:0] rast_x;
    logic [10:0] rast_y;
    logic [15:0] rast_z;
    logic [1:0]  rast_color;
    logic        fill_start;
    logic [10:0] fill_x0;
    logic [10:0] fill_y0;
    logic [10:0] fill_x1;
    logic [10:0] fill_y1;
    logic [15:0] fill_z;
    logic [1:0]  fill_color;
    logic        fill_busy;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] z;
    logic [1:0]  pixel_color;
    logic        pixel_write;
    logic [15:0] drop_count;

    modport slave (
        input  rast_valid, rast_x, rast_y, rast_z, rast_color,
        input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_z, fill_color,
        output rast_ready, fill_busy, x, y, z, pixel_color, pixel_write, drop_count
    );

    modport master (
        output rast_valid, rast_x, rast_y, rast_z, rast_color,
        output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_z, fill_color,
        input  rast_ready, fill_busy, x, y, z, pixel_color, pixel_write, drop_count
    );
endinterface

// File: rtl/fb_write_sched.sv
// Shares the framebuffer pixel-write port between the rasterizer stream and a
// rectangle-fill engine, round-robin on contention, dropping off-screen pixels.
module fb_write_sched #(
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input  logic             clk50,
    input  logic             reset,
    fb_write_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [10:0] XLIM  = 11'(XMAX);
    localparam logic [10:0] YLIM  = 11'(YMAX);
    localparam logic [10:0] XLAST = 11'(XMAX - 1);
    localparam logic [10:0] YLAST = 11'(YMAX - 1);

    state_t      r_state;
    logic        r_lastGrantR;
    logic [10:0] r_cursorX;
    logic [10:0] r_cursorY;
    logic [10:0] r_fillX0;
    logic [10:0] r_fillX1;
    logic [10:0] r_fillY1;
    logic [15:0] r_fillZ;
    logic [1:0]  r_fillColor;
    logic        r_busy;
    logic [10:0] r_outX;
    logic [10:0] r_outY;
    logic [15:0] r_outZ;
    logic [1:0]  r_outColor;
    logic        r_write;
    logic [15:0] r_dropCount;

    logic [10:0] w_x1Clamped;
    logic [10:0] w_y1Clamped;
    logic        w_cmdOk;
    logic        w_rastReady;
    logic        w_grantR;
    logic        w_grantF;
    logic        w_rastInRange;
    logic        w_fillLast;

    assign w_x1Clamped   = (bus.fill_x1 > XLAST) ? XLAST : bus.fill_x1;
    assign w_y1Clamped   = (bus.fill_y1 > YLAST) ? YLAST : bus.fill_y1;
    assign w_cmdOk       = (bus.fill_x0 <= w_x1Clamped) && (bus.fill_y0 <= w_y1Clamped)
                           && (bus.fill_x0 < XLIM) && (bus.fill_y0 < YLIM);

    // The rasterizer is held off only when the fill is owed its turn.
    assign w_rastReady   = !((r_state == RUN) && r_lastGrantR);
    assign w_grantR      = bus.rast_valid && w_rastReady;
    assign w_grantF      = (r_state == RUN) && !w_grantR;
    assign w_rastInRange = (bus.rast_x < XLIM) && (bus.rast_y < YLIM);
    assign w_fillLast    = (r_cursorX == r_fillX1) && (r_cursorY == r_fillY1);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGrantR <= 1'b0;
            r_cursorX    <= '0;
            r_cursorY    <= '0;
            r_fillX0     <= '0;
            r_fillX1     <= '0;
            r_fillY1     <= '0;
            r_fillZ      <= '0;
            r_fillColor  <= '0;
            r_busy       <= 1'b0;
            r_outX       <= '0;
            r_outY       <= '0;
            r_outZ       <= '0;
            r_outColor   <= '0;
            r_write      <= 1'b0;
            r_dropCount  <= '0;
        end else begin
            r_write <= 1'b0;

            if (w_grantR) begin
                r_lastGrantR <= 1'b1;
                if (w_rastInRange) begin
                    r_outX     <= bus.rast_x;
                    r_outY     <= bus.rast_y;
                    r_outZ     <= bus.rast_z;
                    r_outColor <= bus.rast_color;
                    r_write    <= 1'b1;
                end else if (r_dropCount != 16'hFFFF) begin
                    r_dropCount <= r_dropCount + 16'd1;
                end
            end else if (w_grantF) begin
                r_lastGrantR <= 1'b0;
                r_outX       <= r_cursorX;
                r_outY       <= r_cursorY;
                r_outZ       <= r_fillZ;
                r_outColor   <= r_fillColor;
                r_write      <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.fill_start && w_cmdOk) begin
                        r_fillX0    <= bus.fill_x0;
                        r_fillX1    <= w_x1Clamped;
                        r_fillY1    <= w_y1Clamped;
                        r_fillZ     <= bus.fill_z;
                        r_fillColor <= bus.fill_color;
                        r_cursorX   <= bus.fill_x0;
                        r_cursorY   <= bus.fill_y0;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_grantF) begin
                        if (w_fillLast) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else if (r_cursorX == r_fillX1) begin
                            r_cursorX <= r_fillX0;
                            r_cursorY <= r_cursorY + 11'd1;
                        end else begin
                            r_cursorX <= r_cursorX + 11'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rast_ready  = w_rastReady;
    assign bus.fill_busy   = r_busy;
    assign bus.x           = r_outX;
    assign bus.y           = r_outY;
    assign bus.z           = r_outZ;
    assign bus.pixel_color = r_outColor;
    assign bus.pixel_write = r_write;
    assign bus.drop_count  = r_dropCount;
endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: a per-cycle vector table for the basic fill,
// stream and command cases, then hand sequences for contention, reset and saturation.
module tb_fb_write_sched;
    localparam logic [15:0] RAST_Z = 16'h1234;
    localparam logic [1:0]  RAST_C = 2'b10;

    typedef struct {
        logic        rv;
        logic [10:0] rx;
        logic [10:0] ry;
        logic        fs;
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
        logic [15:0] fz;
        logic [1:0]  fc;
        logic        expRdy;
        logic        expWr;
        logic [10:0] expX;
        logic [10:0] expY;
        logic [15:0] expZ;
        logic [1:0]  expC;
        logic        expBusy;
        logic [15:0] expDrop;
    } vec_t;

    logic clk50;
    logic reset;
    int   nChecks;
    int   nFail;
    vec_t vecs[$];

    fb_write_sched_if bus();

    fb_write_sched dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic addVec(input logic rv, input logic [10:0] rx, input logic [10:0] ry,
                          input logic fs, input logic [10:0] x0, input logic [10:0] y0,
                          input logic [10:0] x1, input logic [10:0] y1,
                          input logic [15:0] fz, input logic [1:0] fc,
                          input logic rdy, input logic wr, input logic [10:0] ex,
                          input logic [10:0] ey, input logic [15:0] ez, input logic [1:0] ec,
                          input logic busy, input logic [15:0] drop);
        vec_t v;
        v.rv = rv; v.rx = rx; v.ry = ry; v.fs = fs;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.fz = fz; v.fc = fc;
        v.expRdy = rdy; v.expWr = wr; v.expX = ex; v.expY = ey;
        v.expZ = ez; v.expC = ec; v.expBusy = busy; v.expDrop = drop;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.rast_valid = v.rv;
        bus.rast_x     = v.rx;
        bus.rast_y     = v.ry;
        bus.rast_z     = RAST_Z;
        bus.rast_color = RAST_C;
        bus.fill_start = v.fs;
        bus.fill_x0    = v.x0;
        bus.fill_y0    = v.y0;
        bus.fill_x1    = v.x1;
        bus.fill_y1    = v.y1;
        bus.fill_z     = v.fz;
        bus.fill_color = v.fc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveRast(input logic rv, input logic [10:0] rx, input logic [10:0] ry);
        bus.rast_valid = rv;
        bus.rast_x     = rx;
        bus.rast_y     = ry;
        bus.rast_z     = RAST_Z;
        bus.rast_color = RAST_C;
    endtask

    task automatic driveFill(input logic fs, input logic [10:0] x0, input logic [10:0] y0,
                             input logic [10:0] x1, input logic [10:0] y1);
        bus.fill_start = fs;
        bus.fill_x0    = x0;
        bus.fill_y0    = y0;
        bus.fill_x1    = x1;
        bus.fill_y1    = y1;
        bus.fill_z     = 16'd9;
        bus.fill_color = 2'b11;
    endtask

    task automatic doReset();
        @(negedge clk50);
        reset = 1'b1;
        driveRast(1'b0, 11'd0, 11'd0);
        driveFill(1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
        repeat (2) @(negedge clk50);
        reset = 1'b0;
    endtask

    initial begin
        int writes;
        nChecks = 0;
        nFail   = 0;
        reset   = 1'b1;
        driveRast(1'b0, 11'd0, 11'd0);
        driveFill(1'b0, 11'd0, 11'd0, 11'd0, 11'd0);

        // Per-cycle table: inputs for the cycle and the outputs seen during it.
        addVec(0,0,0,     1,10,20,11,21, 16'd5,2'b01, 1,0,0,0,0,0,             0,0);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             1,0);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,10,20,16'd5,2'b01,   1,0);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,11,20,16'd5,2'b01,   1,0);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,10,21,16'd5,2'b01,   1,0);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,11,21,16'd5,2'b01,   0,0);
        addVec(1,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,0);
        addVec(1,639,479, 0,0,0,0,0,     16'd0,2'b00, 1,1,0,0,RAST_Z,RAST_C,   0,0);
        addVec(1,640,0,   0,0,0,0,0,     16'd0,2'b00, 1,1,639,479,RAST_Z,RAST_C, 0,0);
        addVec(1,5,480,   0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,1);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,2);
        addVec(0,0,0,     1,5,5,4,9,     16'd3,2'b01, 1,0,0,0,0,0,             0,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,2);
        addVec(0,0,0,     1,638,0,700,0, 16'd7,2'b11, 1,0,0,0,0,0,             0,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 0,0,0,0,0,0,             1,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,638,0,16'd7,2'b11,   1,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,1,639,0,16'd7,2'b11,   0,2);
        addVec(0,0,0,     0,0,0,0,0,     16'd0,2'b00, 1,0,0,0,0,0,             0,2);

        repeat (2) @(negedge clk50);
        #1;
        checkOutput("reset_write", 32'(bus.pixel_write), 32'd0);
        checkOutput("reset_busy",  32'(bus.fill_busy),   32'd0);
        checkOutput("reset_ready", 32'(bus.rast_ready),  32'd1);
        checkOutput("reset_drop",  32'(bus.drop_count),  32'd0);
        checkOutput("reset_x",     32'(bus.x),           32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk50);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_ready", i), 32'(bus.rast_ready),  32'(vecs[i].expRdy));
            checkOutput($sformatf("v%0d_write", i), 32'(bus.pixel_write), 32'(vecs[i].expWr));
            checkOutput($sformatf("v%0d_busy", i),  32'(bus.fill_busy),   32'(vecs[i].expBusy));
            checkOutput($sformatf("v%0d_drop", i),  32'(bus.drop_count),  32'(vecs[i].expDrop));
            if (vecs[i].expWr) begin
                checkOutput($sformatf("v%0d_x", i), 32'(bus.x),           32'(vecs[i].expX));
                checkOutput($sformatf("v%0d_y", i), 32'(bus.y),           32'(vecs[i].expY));
                checkOutput($sformatf("v%0d_z", i), 32'(bus.z),           32'(vecs[i].expZ));
                checkOutput($sformatf("v%0d_c", i), 32'(bus.pixel_color), 32'(vecs[i].expC));
            end
        end

        // Contention: fresh reset so the first tie goes to the rasterizer.
        doReset();
        @(negedge clk50);
        driveFill(1'b1, 11'd0, 11'd0, 11'd3, 11'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk50);
            driveFill(1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
            driveRast(k < 9, 11'd100, 11'd100);
            #1;
            if (k <= 9)
                checkOutput($sformatf("cont%0d_ready", k), 32'(bus.rast_ready), 32'(k % 2));
            checkOutput($sformatf("cont%0d_write", k), 32'(bus.pixel_write), 32'(k >= 2 && k <= 9));
            checkOutput($sformatf("cont%0d_busy", k),  32'(bus.fill_busy),   32'(k <= 8));
            if (k >= 2 && k <= 9) begin
                checkOutput($sformatf("cont%0d_x", k), 32'(bus.x), (k % 2 == 0) ? 32'd100 : 32'((k - 3) / 2));
                checkOutput($sformatf("cont%0d_y", k), 32'(bus.y), (k % 2 == 0) ? 32'd100 : 32'd0);
            end
        end

        // Reset in the middle of a 10-pixel fill, with a nonzero drop count.
        doReset();
        @(negedge clk50);
        driveRast(1'b1, 11'd700, 11'd5);
        @(negedge clk50);
        driveRast(1'b0, 11'd0, 11'd0);
        #1;
        checkOutput("mid_drop_pre", 32'(bus.drop_count), 32'd1);
        @(negedge clk50);
        driveFill(1'b1, 11'd0, 11'd0, 11'd9, 11'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk50);
            driveFill(1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
        end
        #1;
        checkOutput("mid_write3", 32'(bus.pixel_write), 32'd1);
        checkOutput("mid_x3",     32'(bus.x),           32'd2);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_write", 32'(bus.pixel_write), 32'd0);
        checkOutput("mid_rst_busy",  32'(bus.fill_busy),   32'd0);
        checkOutput("mid_rst_drop",  32'(bus.drop_count),  32'd0);
        @(negedge clk50);
        reset  = 1'b0;
        writes = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk50);
            #1;
            if (bus.pixel_write === 1'b1 || bus.fill_busy === 1'b1) writes++;
        end
        checkOutput("mid_after_writes", 32'(writes), 32'd0);

        // Drop counter saturation with a stream of off-screen pixels.
        doReset();
        @(negedge clk50);
        driveRast(1'b1, 11'd700, 11'd0);
        for (int i = 1; i <= 65534; i++) @(negedge clk50);
        #1;
        checkOutput("sat_preload", 32'(bus.drop_count), 32'h0000FFFE);
        repeat (3) @(negedge clk50);
        driveRast(1'b0, 11'd0, 11'd0);
        #1;
        checkOutput("sat_top", 32'(bus.drop_count), 32'h0000FFFF);
        @(negedge clk50);
        #1;
        checkOutput("sat_hold",  32'(bus.drop_count),  32'h0000FFFF);
        checkOutput("sat_write", 32'(bus.pixel_write), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule
